// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared types and constants for the rv32i memory sequencer:
//                sequencer state encoding, the LOAD major opcode and the NOP
//                instruction word that the instruction register resets to.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DEC    = 3'd1,
    ST_EXEC   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_EXT    = 3'd5,
    ST_EXT_RD = 3'd6
  } state_t;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/rv32i_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_memarb
//  Description : Multi-cycle sequencer letting a single-cycle rv32i core run
//                from one synchronous single-port RAM. Fetches into a held
//                instruction register, issues the data access, and pulses
//                core_step_o to commit the core's PC / register-file update.
//                Optional external-master arbitration at instruction
//                boundaries is compiled in with RV32I_MEMARB_EXT_EN.
//  Ports       : clk_i / rst_i (async, active-high)
//                core_*   : core fetch/data request, IR and load data back
//                ram_*    : synchronous single-port RAM (1-cycle read latency)
//                ext_*    : external master (RV32I_MEMARB_EXT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_memarb
  import rv32i_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       core_instr_addr_i,
  output logic [31:0]       core_instr_o,
  input  logic [31:0]       core_mem_addr_i,
  input  logic [31:0]       core_mem_dout_i,
  input  logic              core_mem_we_i,
  input  logic [3:0]        core_mem_be_i,
  output logic [31:0]       core_mem_din_o,
  output logic              core_step_o,
  output logic [MEM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  input  logic [31:0]       ram_dout_i
`ifdef RV32I_MEMARB_EXT_EN
  ,
  input  logic              ext_req_i,
  input  logic [31:0]       ext_addr_i,
  input  logic [31:0]       ext_wdata_i,
  input  logic              ext_we_i,
  input  logic [3:0]        ext_be_i,
  output logic              ext_gnt_o,
  output logic [31:0]       ext_rdata_o,
  output logic              ext_rvalid_o
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_ldbuf;
  logic        w_ir_is_load;

  // Only word-address bits reach the RAM; the rest are intentionally dropped
  // (byte offset ignored, upper bits wrap).
  logic        w_unused_addr_bits;
`ifdef RV32I_MEMARB_EXT_EN
  assign w_unused_addr_bits = ^{core_instr_addr_i, core_mem_addr_i, ext_addr_i};
`else
  assign w_unused_addr_bits = ^{core_instr_addr_i, core_mem_addr_i};
`endif

  assign w_ir_is_load   = (r_ir[6:0] == OPC_LOAD);
  assign core_instr_o   = r_ir;
  assign core_mem_din_o = r_ldbuf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_FETCH;
      r_ir    <= INSTR_NOP;
      r_ldbuf <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DEC) begin
        r_ir <= ram_dout_i;
      end
      if (r_state == ST_LOAD) begin
        r_ldbuf <= ram_dout_i;
      end
    end
  end

`ifdef RV32I_MEMARB_EXT_EN
  // Set once the external master has been served; cleared by the next core
  // commit so the core always retires one instruction between grants.
  logic r_ext_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ext_done <= 1'b0;
    end else if (r_state == ST_EXT) begin
      r_ext_done <= 1'b1;
    end else if (core_step_o) begin
      r_ext_done <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_next       = r_state;
    ram_addr_o   = core_instr_addr_i[MEM_AW+1:2];
    ram_din_o    = core_mem_dout_i;
    ram_be_o     = core_mem_be_i;
    ram_we_o     = 1'b0;
    core_step_o  = 1'b0;
`ifdef RV32I_MEMARB_EXT_EN
    ext_gnt_o    = 1'b0;
    ext_rdata_o  = '0;
    ext_rvalid_o = 1'b0;
`endif
    case (r_state)
      ST_FETCH: begin
        w_next = ST_DEC;
`ifdef RV32I_MEMARB_EXT_EN
        if (ext_req_i && !r_ext_done) begin
          w_next = ST_EXT;
        end
`endif
      end
      ST_DEC: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        ram_addr_o = core_mem_addr_i[MEM_AW+1:2];
        if (w_ir_is_load) begin
          w_next = ST_LOAD;
        end else begin
          // Stores and everything else commit here; a store writes in the
          // same cycle as the step pulse.
          ram_we_o    = core_mem_we_i;
          core_step_o = 1'b1;
          w_next      = ST_FETCH;
        end
      end
      ST_LOAD: begin
        w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        core_step_o = 1'b1;
        w_next      = ST_FETCH;
      end
`ifdef RV32I_MEMARB_EXT_EN
      ST_EXT: begin
        ext_gnt_o  = 1'b1;
        ram_addr_o = ext_addr_i[MEM_AW+1:2];
        ram_din_o  = ext_wdata_i;
        ram_be_o   = ext_be_i;
        ram_we_o   = ext_we_i;
        w_next     = ext_we_i ? ST_FETCH : ST_EXT_RD;
      end
      ST_EXT_RD: begin
        ext_rvalid_o = 1'b1;
        ext_rdata_o  = ram_dout_i;
        w_next       = ST_FETCH;
      end
`endif
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_memarb
//  Description : Self-checking bench for rv32i_memarb. Acts as the core and
//                the RAM, runs directed and random instruction streams and
//                compares against a word-level memory model and per-class
//                instruction latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv32i_memarb;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc, maddr, mdout;
  logic [3:0]  mbe;
  logic        mwe;
  logic [31:0] instr_o, din_o, rdin, rdout;
  logic        step, rwe;
  logic [11:0] raddr;
  logic [3:0]  rbe;

  logic [31:0] ram   [0:4095];
  logic [31:0] model [0:4095];

  int total = 0;
  int bad   = 0;

  // Core side: store request decoded from the held instruction.
  assign mwe = (instr_o[6:0] == 7'b0100011);

`ifdef RV32I_MEMARB_EXT_EN
  logic        ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [3:0]  ext_be;
`endif

  rv32i_memarb #(.MEM_AW(12)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_instr_addr_i(pc), .core_instr_o(instr_o),
    .core_mem_addr_i(maddr), .core_mem_dout_i(mdout),
    .core_mem_we_i(mwe), .core_mem_be_i(mbe),
    .core_mem_din_o(din_o), .core_step_o(step),
    .ram_addr_o(raddr), .ram_din_o(rdin), .ram_we_o(rwe),
    .ram_be_o(rbe), .ram_dout_i(rdout)
`ifdef RV32I_MEMARB_EXT_EN
    ,
    .ext_req_i(ext_req), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_we_i(ext_we), .ext_be_i(ext_be), .ext_gnt_o(ext_gnt),
    .ext_rdata_o(ext_rdata), .ext_rvalid_o(ext_rvalid)
`endif
  );

  // Narrow-address instance for the wrap check.
  logic        d4_rst;
  logic [31:0] d4_pc    = 32'h0000_0040;
  logic [31:0] d4_maddr = 32'h0000_0044;
  logic [31:0] d4_zero  = 32'h0;
  logic [3:0]  d4_be    = 4'hF;
  logic        d4_we    = 1'b1;
  logic [31:0] d4_rdout = 32'h0020_A023;   // sw x2,0(x1)
  logic [3:0]  d4_raddr;
  logic        d4_rwe, d4_step;
  logic [31:0] d4_unused_instr, d4_unused_din, d4_unused_rdin;
  logic [3:0]  d4_unused_rbe;
`ifdef RV32I_MEMARB_EXT_EN
  logic        d4_unused_gnt, d4_unused_rvalid;
  logic [31:0] d4_unused_rdata;
`endif

  rv32i_memarb #(.MEM_AW(4)) dut4 (
    .clk_i(clk), .rst_i(d4_rst),
    .core_instr_addr_i(d4_pc), .core_instr_o(d4_unused_instr),
    .core_mem_addr_i(d4_maddr), .core_mem_dout_i(d4_zero),
    .core_mem_we_i(d4_we), .core_mem_be_i(d4_be),
    .core_mem_din_o(d4_unused_din), .core_step_o(d4_step),
    .ram_addr_o(d4_raddr), .ram_din_o(d4_unused_rdin), .ram_we_o(d4_rwe),
    .ram_be_o(d4_unused_rbe), .ram_dout_i(d4_rdout)
`ifdef RV32I_MEMARB_EXT_EN
    ,
    .ext_req_i(1'b0), .ext_addr_i(d4_zero), .ext_wdata_i(d4_zero),
    .ext_we_i(1'b0), .ext_be_i(4'h0), .ext_gnt_o(d4_unused_gnt),
    .ext_rdata_o(d4_unused_rdata), .ext_rvalid_o(d4_unused_rvalid)
`endif
  );

  // Synchronous single-port RAM, read-before-write, byte enables.
  always @(posedge clk) begin
    rdout <= ram[raddr];
    if (rwe) begin
      for (int b = 0; b < 4; b++) begin
        if (rbe[b]) ram[raddr][8*b +: 8] = rdin[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int kind, input logic [4:0] rd, input logic [11:0] imm);
    if (kind == K_LOAD)  return {imm, 5'd2, 3'b010, rd, 7'b0000011};
    if (kind == K_STORE) return {imm[11:5], 5'd3, 5'd2, 3'b010, imm[4:0], 7'b0100011};
    return {imm, 5'd1, 3'b000, rd, 7'b0010011};
  endfunction

  // Runs one instruction. Entry and exit: at a falling edge with the
  // sequencer ready to fetch.
  task automatic exec_one(input int kind, input logic [31:0] ipc, input logic [31:0] ma,
                          input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r, iw;
    int          exp_last;
    bit          seen;
    r  = $urandom;
    iw = enc(kind, r[11:7], r[31:20]);
    ram[ipc[13:2]]   = iw;
    model[ipc[13:2]] = iw;
    pc = ipc; maddr = ma; mdout = wd; mbe = be;
    exp_last = (kind == K_LOAD) ? 4 : 2;
    seen = 0;
    for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cyc == 0) chk("fetch_addr", 32'(raddr), 32'(ipc[13:2]));
      if (cyc == 2 && kind != K_ALU) chk("exec_addr", 32'(raddr), 32'(ma[13:2]));
      chk("ram_we", 32'(rwe), (kind == K_STORE && cyc == 2) ? 32'd1 : 32'd0);
      if (step) begin
        seen = 1;
        chk("latency", 32'(cyc), 32'(exp_last));
        chk("ir", instr_o, iw);
        if (kind == K_LOAD) chk("load_data", din_o, model[ma[13:2]]);
        if (kind == K_STORE) begin
          chk("store_be", 32'(rbe), 32'(be));
          chk("store_din", rdin, wd);
          for (int b = 0; b < 4; b++)
            if (be[b]) model[ma[13:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    if (!seen) chk("step_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int errs;
    for (int i = 0; i < 4096; i++) begin
      ram[i]   = $urandom;
      model[i] = ram[i];
    end
    rst = 1'b1; d4_rst = 1'b1;
    pc = 32'h0; maddr = 32'h0; mdout = 32'h0; mbe = 4'h0;
`ifdef RV32I_MEMARB_EXT_EN
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0; ext_be = 4'h0;
`endif

    // Reset state
    #12;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_we", 32'(rwe), 32'd0);
    chk("rst_addr", 32'(raddr), 32'd0);
    chk("rst_ir", instr_o, 32'h0000_0013);
    chk("rst_ldbuf", din_o, 32'd0);
`ifdef RV32I_MEMARB_EXT_EN
    chk("rst_gnt", 32'(ext_gnt), 32'd0);
    chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rst_rdata", ext_rdata, 32'd0);
`endif

    // Narrow RAM: data address 0x44 wraps to word 1
    @(negedge clk); d4_rst = 1'b0; #1;
    chk("w4_fetch_addr", 32'(d4_raddr), 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("w4_exec_addr", 32'(d4_raddr), 32'h1);
    chk("w4_exec_we", 32'(d4_rwe), 32'd1);
    chk("w4_exec_step", 32'(d4_step), 32'd1);

    // Release main reset and run directed instructions
    @(negedge clk); rst = 1'b0;
    exec_one(K_ALU, 32'h0, 32'h0, 32'h0, 4'h0);
    ram[32'h10] = 32'hDEAD_BEEF; model[32'h10] = 32'hDEAD_BEEF;
    exec_one(K_LOAD, 32'h8, 32'h40, 32'h0, 4'h0);
    exec_one(K_STORE, 32'hC, 32'h44, 32'h1234_5678, 4'b0011);

    // Asynchronous reset while a load is in flight
    ram[4] = enc(K_LOAD, 5'd5, 12'h0); model[4] = ram[4];
    pc = 32'h10; maddr = 32'h48;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    chk("load_no_step", 32'(step), 32'd0);
    rst = 1'b1; #1;
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_we", 32'(rwe), 32'd0);
    chk("midrst_ir", instr_o, 32'h0000_0013);
    chk("midrst_addr", 32'(raddr), 32'h4);
    @(negedge clk); rst = 1'b0;
    exec_one(K_ALU, 32'h10, 32'h0, 32'h0, 4'h0);

`ifdef RV32I_MEMARB_EXT_EN
    begin
      int  gc[$], vc[$], sc[$];
      int  between;
      bit  step_prev;
      logic [31:0] rd_exp;
      rd_exp = ram[32'h40];
      ram[8] = enc(K_ALU, 5'd1, 12'h1); model[8] = ram[8];
      ram[9] = enc(K_ALU, 5'd2, 12'h2); model[9] = ram[9];
      pc = 32'h20; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h100; ext_be = 4'hF;
      ext_wdata = 32'hCAFE_F00D;
      step_prev = 0;
      for (int cyc = 0; cyc < 11; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (step_prev) pc = pc + 32'd4;
        #1;
        step_prev = step;
        chk("ext_ram_we", 32'(rwe), (cyc == 7) ? 32'd1 : 32'd0);
        if (step) sc.push_back(cyc);
        if (ext_rvalid) begin
          vc.push_back(cyc);
          chk("ext_rdata", ext_rdata, rd_exp);
          ext_we = 1'b1; ext_addr = 32'h104;
        end
        if (ext_gnt) begin
          gc.push_back(cyc);
          chk("ext_gnt_addr", 32'(raddr), (gc.size() == 1) ? 32'h40 : 32'h41);
          if (gc.size() == 2) ext_req = 1'b0;
        end
      end
      model[32'h41] = 32'hCAFE_F00D;
      chk("ext_gnt_count", 32'(gc.size()), 32'd2);
      chk("ext_gnt0_cyc", (gc.size() > 0) ? 32'(gc[0]) : 32'hFFFF, 32'd1);
      chk("ext_gnt1_cyc", (gc.size() > 1) ? 32'(gc[1]) : 32'hFFFF, 32'd7);
      chk("ext_rvalid_cyc", (vc.size() == 1) ? 32'(vc[0]) : 32'hFFFF, 32'd2);
      chk("ext_step_count", 32'(sc.size()), 32'd2);
      between = 0;
      foreach (sc[k]) if (gc.size() > 1 && sc[k] > gc[0] && sc[k] < gc[1]) between++;
      chk("ext_steps_between", 32'(between), 32'd1);
      ext_we = 1'b0;
      @(negedge clk);
    end
`endif

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [31:0] ma;
      kind = $urandom_range(0, 2);
      ma   = 32'h400 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      exec_one(kind, 32'h300 + 32'(i * 4), ma, $urandom, 4'($urandom_range(0, 15)));
    end

    // Whole-memory comparison catches missing or stray writes
    errs = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== model[i]) errs++;
    chk("mem_sweep", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
